// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: turns the 240 Hz frame tick into quarter/half-frame
// clock pulses and the frame interrupt, in 4-step or 5-step mode ($4017).
module apu_frame_sequencer (
  input  logic       cpu_clk,
  input  logic       rst,
  input  logic       clk_240Hz,
  input  logic       reg_wr,
  input  logic [7:0] reg_wdata,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step_cnt,
  output logic       stepSel
);

  localparam logic [2:0] STEP0 = 3'd0;
  localparam logic [2:0] STEP1 = 3'd1;
  localparam logic [2:0] STEP2 = 3'd2;
  localparam logic [2:0] STEP3 = 3'd3;
  localparam logic [2:0] STEP4 = 3'd4;

  logic       sync1_q, sync2_q, edge_q, tick_q;
  logic       rise;
  logic [2:0] step_q, step_d;
  logic [2:0] last_step;
  logic       sel_q, sel_d;
  logic       inh_q, inh_d;
  logic       irq_q, irq_d;
  logic       qf_q, qf_d;
  logic       hf_q, hf_d;

  // The detected rise is registered once more so the step pulses land on
  // the third edge after the first edge that samples the tick high.
  assign rise      = sync2_q & ~edge_q;
  assign last_step = sel_q ? STEP4 : STEP3;

  always_comb begin
    step_d = step_q;
    sel_d  = sel_q;
    inh_d  = inh_q;
    irq_d  = irq_q;
    qf_d   = 1'b0;
    hf_d   = 1'b0;

    if (irq_ack) irq_d = 1'b0;

    if (reg_wr) begin
      // A write takes priority over a coincident tick, which is dropped.
      step_d = STEP0;
      sel_d  = reg_wdata[7];
      inh_d  = reg_wdata[6];
      qf_d   = reg_wdata[7];
      hf_d   = reg_wdata[7];
      if (reg_wdata[6]) irq_d = 1'b0;
    end else if (tick_q) begin
      case (step_q)
        STEP0, STEP2: qf_d = 1'b1;
        STEP1, STEP4: begin
          qf_d = 1'b1;
          hf_d = 1'b1;
        end
        STEP3: begin
          if (!sel_q) begin
            qf_d = 1'b1;
            hf_d = 1'b1;
            if (!inh_q) irq_d = 1'b1;
          end
        end
        default: ;
      endcase
      step_d = (step_q >= last_step) ? STEP0 : step_q + 3'd1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      tick_q  <= 1'b0;
      step_q  <= STEP0;
      sel_q   <= 1'b0;
      inh_q   <= 1'b0;
      irq_q   <= 1'b0;
      qf_q    <= 1'b0;
      hf_q    <= 1'b0;
    end else begin
      sync1_q <= clk_240Hz;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      tick_q  <= rise;
      step_q  <= step_d;
      sel_q   <= sel_d;
      inh_q   <= inh_d;
      irq_q   <= irq_d;
      qf_q    <= qf_d;
      hf_q    <= hf_d;
    end
  end

  assign quarter_frame = qf_q;
  assign half_frame    = hf_q;
  assign frame_irq     = irq_q;
  assign step_cnt      = step_q;
  assign stepSel       = sel_q;

endmodule
